simeck_keyctl: RTL and testbench
================================

SIMECK_KEYCTL -- requirements
Module: simeck_keyctl

Interface
REQ-001 Parameter DATAW, default 16: width of one key word and of the round constant.
REQ-002 Parameter ROUNDS, default 32: number of round-key cycles per run (32/36/44 for Simeck32/48/64).
REQ-003 Parameter ZSEL, default 0: selects the constant sequence (0 = z0 5-bit LFSR, 1 = z1 6-bit LFSR).
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to begin a key-schedule run; sampled only in IDLE.
REQ-007 key_in  input  4*DATAW  master key; word j occupies bits [j*DATAW +: DATAW].
REQ-008 key_word  output  DATAW  word driven to the key-schedule key input.
REQ-009 kctr  output  1  load select to the key schedule (1 = load key_word, 0 = iterate).
REQ-010 k  output  DATAW  round constant to the key schedule.
REQ-011 rk_valid  output  1  high on cycles where the key-schedule output register holds round key rnd.
REQ-012 rnd  output  8  current round index, 0..ROUNDS-1.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse after the last round key.

Function
REQ-015 FSM states: IDLE, LOAD, RUN, DONE; the encoding is fixed in the package.
REQ-016 IDLE→LOAD when start=1; key_in is captured into an internal 4-word buffer on that edge.
REQ-017 LOAD lasts exactly 4 cycles: kctr=1 and key_word = buffer word 0, 1, 2, 3 in successive cycles.
REQ-018 LOAD→RUN after the 4th load cycle; RUN lasts exactly ROUNDS cycles with kctr=0.
REQ-019 In RUN, k = (2^DATAW − 4) XOR z_i, with z_i in bit 0, for i = 0..ROUNDS−1; one z bit per RUN cycle.
REQ-020 z0 sequence: state initialised to 5'b11111 on entry to LOAD; z_{i+5} = z_{i+2} XOR z_i; z_i is the LSB of the state.
REQ-021 z1 sequence: state initialised to 6'b111111 on entry to LOAD; z_{i+6} = z_{i+1} XOR z_i.
REQ-022 The LFSR advances only in RUN and holds in IDLE, LOAD and DONE.
REQ-023 rk_valid=1 and rnd=0 on the first RUN cycle; rnd increments by 1 each RUN cycle, with no wrap inside a run.
REQ-024 RUN→DONE after rnd = ROUNDS−1; done=1 for exactly one cycle in DONE, then DONE→IDLE.
REQ-025 start asserted while busy=1 is ignored; a new run needs start in IDLE, so a start held high re-arms on the IDLE cycle after DONE.
REQ-026 Outside LOAD/RUN: kctr=0, key_word=0, k=0, rk_valid=0, rnd holds its last value.
REQ-027 Total latency from the start edge to the done pulse is 4 + ROUNDS + 1 cycles.

Reset
REQ-028 reset=0 forces immediately, independent of clk: state=IDLE, buffer=0, LFSR=all-ones, rnd=0, every output 0.
REQ-029 Reset during LOAD or RUN abandons the run; no done pulse is produced.
REQ-030 Normal operation resumes on the first rising clk edge after reset returns high.

Configuration
REQ-031 Macro SIMECK_KEYCTL_ABORT_EN: when defined, adds input abort (1 bit).
REQ-032 With the macro defined, abort=1 in LOAD or RUN returns the FSM to IDLE on the next edge: no done pulse, outputs as in REQ-026, rnd cleared to 0.
REQ-033 Without the macro, no abort port exists and a run always completes.

Structure
REQ-034 Shared package simeck_pkg holds: the FSM state typedef, z0/z1 initial values and tap positions, and the ROUNDS values per Simeck variant.
REQ-035 Sub-module simeck_zlfsr, parameterised by ZSEL, provides init/step inputs and a z output; all other logic stays in simeck_keyctl.

Verification
REQ-036 DATAW=16, ZSEL=0, key_in=0x1918_1110_0908_0100, start pulse → key_word = 0x0100, 0x0908, 0x1110, 0x1918 with kctr=1, then kctr=0.
REQ-037 Same run → k for rounds 0..9 = FFFD, FFFD, FFFD, FFFD, FFFD, FFFC, FFFC, FFFC, FFFD, FFFD.
REQ-038 Same run → rk_valid high for 32 cycles, rnd 0..31, done pulse 37 cycles after the start edge, busy low on the next cycle.
REQ-039 ZSEL=1, ROUNDS=44, DATAW=32 → k bit 0 for rounds 0..10 = 1,1,1,1,1,1,0,0,0,0,0; done after 49 cycles.
REQ-040 reset pulsed low at rnd=10, then start → fresh run with rnd=0 and k sequence restarting at FFFD; no done from the aborted run.
REQ-041 start held high continuously → back-to-back runs separated by exactly one IDLE cycle; with SIMECK_KEYCTL_ABORT_EN, abort at rnd=5 → IDLE next cycle, done never asserted.

Source files
------------

// File: rtl/simeck_pkg.sv
// Shared definitions for the Simeck key-schedule controller: FSM encoding,
// z-sequence LFSR seeds/taps and round counts per Simeck variant.
package simeck_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } kst_t;

    // z0: z[i+5] = z[i+2] ^ z[i];  z1: z[i+6] = z[i+1] ^ z[i]
    localparam int         Z0_LEN  = 5;
    localparam logic [4:0] Z0_INIT = 5'b11111;
    localparam int         Z0_TAP  = 2;
    localparam int         Z1_LEN  = 6;
    localparam logic [5:0] Z1_INIT = 6'b111111;
    localparam int         Z1_TAP  = 1;

    localparam int ROUNDS_SIMECK32 = 32;
    localparam int ROUNDS_SIMECK48 = 36;
    localparam int ROUNDS_SIMECK64 = 44;

endpackage

// File: rtl/simeck_zlfsr.sv
// Round-constant bit generator: z0 (ZSEL=0) or z1 (ZSEL=1) sequence, LSB is the
// current z bit; init reloads the seed, step advances one bit.
module simeck_zlfsr
    import simeck_pkg::*;
#(
    parameter int ZSEL = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic init,
    input  logic step,
    output logic z
);

    localparam int            LW   = (ZSEL != 0) ? Z1_LEN : Z0_LEN;
    localparam logic [LW-1:0] SEED = (ZSEL != 0) ? LW'(Z1_INIT) : LW'(Z0_INIT);
    localparam int            TAP  = (ZSEL != 0) ? Z1_TAP : Z0_TAP;

    logic [LW-1:0] sreg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sreg <= SEED;
        else if (init)
            sreg <= SEED;
        else if (step)
            sreg <= {sreg[0] ^ sreg[TAP], sreg[LW-1:1]};
    end

    assign z = sreg[0];

endmodule

// File: rtl/simeck_keyctl.sv
// Simeck key-schedule controller: loads 4 key words, then drives ROUNDS round
// constants. Optional abort input enabled by macro SIMECK_KEYCTL_ABORT_EN.
module simeck_keyctl
    import simeck_pkg::*;
#(
    parameter int DATAW  = 16,
    parameter int ROUNDS = ROUNDS_SIMECK32,
    parameter int ZSEL   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef SIMECK_KEYCTL_ABORT_EN
    input  logic               abort,
`endif
    input  logic [4*DATAW-1:0] key_in,
    output logic [DATAW-1:0]   key_word,
    output logic               kctr,
    output logic [DATAW-1:0]   k,
    output logic               rk_valid,
    output logic [7:0]         rnd,
    output logic               busy,
    output logic               done
);

    localparam logic [DATAW-1:0] K_BASE   = {{(DATAW-2){1'b1}}, 2'b00};
    localparam logic [7:0]       LAST_RND = 8'(ROUNDS - 1);

    kst_t                   state, state_nx;
    logic [3:0][DATAW-1:0]  kbuf;
    logic [1:0]             lcnt;
    logic                   abort_req;
    logic                   lfsr_init, lfsr_step, z;

`ifdef SIMECK_KEYCTL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    simeck_zlfsr #(.ZSEL(ZSEL)) u_zlfsr (
        .clk   (clk),
        .reset (reset),
        .init  (lfsr_init),
        .step  (lfsr_step),
        .z     (z)
    );

    always_comb begin
        state_nx  = state;
        lfsr_init = 1'b0;
        lfsr_step = 1'b0;
        kctr      = 1'b0;
        key_word  = '0;
        k         = '0;
        rk_valid  = 1'b0;
        busy      = (state != ST_IDLE);
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx  = ST_LOAD;
                    lfsr_init = 1'b1;
                end
            end
            ST_LOAD: begin
                kctr     = 1'b1;
                key_word = kbuf[lcnt];
                if (abort_req)
                    state_nx = ST_IDLE;
                else if (lcnt == 2'd3)
                    state_nx = ST_RUN;
            end
            ST_RUN: begin
                lfsr_step = 1'b1;
                rk_valid  = 1'b1;
                k         = K_BASE ^ DATAW'(z);
                if (abort_req)
                    state_nx = ST_IDLE;
                else if (rnd == LAST_RND)
                    state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kbuf <= '0;
            lcnt <= '0;
            rnd  <= '0;
        end else begin
            if (state == ST_IDLE && start)
                kbuf <= key_in;
            lcnt <= (state == ST_LOAD) ? lcnt + 2'd1 : 2'd0;
            // rnd is left holding its final value after a completed run
            if ((state == ST_LOAD || state == ST_RUN) && abort_req)
                rnd <= '0;
            else if (state == ST_LOAD && lcnt == 2'd3)
                rnd <= '0;
            else if (state == ST_RUN && rnd != LAST_RND)
                rnd <= rnd + 8'd1;
        end
    end

endmodule

// File: tb/tb_simeck_keyctl.sv
// Directed bench for simeck_keyctl: Simeck32 instance (z0) and Simeck64-style
// instance (z1, 32-bit, 44 rounds) driven from one clock and reset.
module tb_simeck_keyctl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    always #5 clk = ~clk;

    logic [63:0]  key0 = 64'h1918_1110_0908_0100;
    logic [127:0] key1 = 128'h1b1a1918_13121110_0b0a0908_03020100;

    logic [15:0] kw0, k0;
    logic [7:0]  rnd0;
    logic        kctr0, rkv0, busy0, done0;
    logic [31:0] kw1, k1;
    logic [7:0]  rnd1;
    logic        kctr1, rkv1, busy1, done1;
`ifdef SIMECK_KEYCTL_ABORT_EN
    logic abort0 = 1'b0;
`endif

    simeck_keyctl #(.DATAW(16), .ROUNDS(32), .ZSEL(0)) u0 (
        .clk(clk), .reset(reset), .start(start0),
`ifdef SIMECK_KEYCTL_ABORT_EN
        .abort(abort0),
`endif
        .key_in(key0), .key_word(kw0), .kctr(kctr0), .k(k0),
        .rk_valid(rkv0), .rnd(rnd0), .busy(busy0), .done(done0)
    );

    simeck_keyctl #(.DATAW(32), .ROUNDS(44), .ZSEL(1)) u1 (
        .clk(clk), .reset(reset), .start(start1),
`ifdef SIMECK_KEYCTL_ABORT_EN
        .abort(1'b0),
`endif
        .key_in(key1), .key_word(kw1), .kctr(kctr1), .k(k1),
        .rk_valid(rkv1), .rnd(rnd1), .busy(busy1), .done(done1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // per-cycle capture, index n = cycles after the start edge (1 = first LOAD)
    logic [15:0] kw0_l [0:127];
    logic [15:0] k0_l  [0:127];
    logic [7:0]  rnd0_l[0:127];
    logic        kc0_l [0:127];
    logic        rv0_l [0:127];
    logic        bz0_l [0:127];
    logic        dn0_l [0:127];
    logic [31:0] k1_l  [0:127];
    logic        rv1_l [0:127];
    logic        dn1_l [0:127];

    task automatic cap(input int ncyc);
        for (int n = 1; n <= ncyc; n++) begin
            if (n > 1) @(negedge clk);
            kw0_l[n] = kw0;  k0_l[n] = k0;   rnd0_l[n] = rnd0;
            kc0_l[n] = kctr0; rv0_l[n] = rkv0; bz0_l[n] = busy0; dn0_l[n] = done0;
            k1_l[n]  = k1;   rv1_l[n] = rkv1; dn1_l[n] = done1;
        end
    endtask

    task automatic go0();
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
    endtask

    task automatic wait_rnd0(input logic [7:0] r, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (rkv0 && rnd0 == r) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    logic [15:0] kexp [0:9] = '{16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFD,
                               16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFD, 16'hFFFD};
    logic [15:0] kwexp[1:4] = '{16'h0100, 16'h0908, 16'h1110, 16'h1918};

    initial begin
        int cnt, errs, first, second, nlow;
        bit ok;
        logic [10:0] zb;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_kctr", kctr0, 0);
        chk("rst_rnd", rnd0, 0);
        chk("rst_k_kw", {k0, kw0, rkv0}, 0);
        reset = 1'b1;
        @(negedge clk);

        // basic Simeck32 run
        go0();
        cap(40);
        for (int n = 1; n <= 4; n++) chk($sformatf("kw%0d", n), kw0_l[n], kwexp[n]);
        chk("kctr_load", {kc0_l[4], kc0_l[3], kc0_l[2], kc0_l[1]}, 4'hF);
        chk("kctr_run", kc0_l[5], 0);
        chk("kw_run", kw0_l[5], 0);
        for (int i = 0; i < 10; i++) chk($sformatf("k_r%0d", i), k0_l[5+i], kexp[i]);
        cnt = 0; errs = 0; first = 0;
        for (int n = 1; n <= 40; n++) begin
            if (rv0_l[n]) cnt++;
            if (n >= 5 && n <= 36 && rnd0_l[n] != 8'(n - 5)) errs++;
            if (dn0_l[n] && first == 0) first = n;
        end
        chk("rkv_cnt", cnt, 32);
        chk("rnd_seq", errs, 0);
        chk("done_at", first, 37);
        chk("done_k", k0_l[37], 0);
        chk("busy_after", bz0_l[38], 0);
        chk("rnd_hold", rnd0_l[38], 31);

        // reset in the middle of a run
        go0();
        wait_rnd0(8'd10, ok);
        chk("reach_r10", ok, 1);
        chk("k_r10", k0, 16'hFFFC);
        reset = 1'b0;
        #1;
        chk("async_busy", busy0, 0);
        chk("async_rnd", {rnd0, rkv0}, 0);
        @(negedge clk) reset = 1'b1;
        cnt = 0;
        repeat (40) begin @(negedge clk); if (done0) cnt++; end
        chk("no_done_rst", cnt, 0);
        go0();
        cap(40);
        chk("fresh_rnd0", rnd0_l[5], 0);
        errs = 0;
        for (int i = 0; i < 10; i++) if (k0_l[5+i] != kexp[i]) errs++;
        chk("fresh_kseq", errs, 0);
        chk("fresh_done", dn0_l[37], 1);

        // start held high: back-to-back runs
        @(negedge clk) start0 = 1'b1;
        @(negedge clk);
        cap(80);
        first = 0; second = 0; nlow = 0;
        for (int n = 1; n <= 80; n++) begin
            if (dn0_l[n]) begin if (first == 0) first = n; else if (second == 0) second = n; end
            if (n <= 75 && !bz0_l[n]) nlow++;
        end
        chk("b2b_done1", first, 37);
        chk("b2b_done2", second, 75);
        chk("b2b_idle", nlow, 1);
        chk("b2b_kw", {kc0_l[39], kw0_l[39]}, {1'b1, 16'h0100});
        start0 = 1'b0;
        repeat (45) @(negedge clk);

        // z1 variant, 32-bit words, 44 rounds
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        cap(55);
        chk("z1_k0", k1_l[5], 32'hFFFF_FFFD);
        for (int i = 0; i < 11; i++) zb[i] = k1_l[5+i][0];
        chk("z1_bits", zb, 11'h03F);
        cnt = 0; first = 0;
        for (int n = 1; n <= 55; n++) begin
            if (rv1_l[n]) cnt++;
            if (dn1_l[n] && first == 0) first = n;
        end
        chk("z1_rkv", cnt, 44);
        chk("z1_done", first, 49);

`ifdef SIMECK_KEYCTL_ABORT_EN
        go0();
        wait_rnd0(8'd5, ok);
        chk("reach_r5", ok, 1);
        abort0 = 1'b1;
        @(negedge clk) abort0 = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_rnd", rnd0, 0);
        cnt = 0;
        repeat (40) begin @(negedge clk); if (done0) cnt++; end
        chk("abort_nodone", cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
